// File: rtl/ct_byte_packer.sv
// rtl/ct_byte_packer.sv - ML-KEM-768 ciphertext ByteEncode serializer
// Reads compressed u/v polynomials from the bank and streams 1088 ciphertext bytes.
module ct_byte_packer #(
  parameter int READ_LAT    = 1,
  parameter int U_SLOT_BASE = 16,
  parameter int V_SLOT      = 19,
  parameter int K           = 3,
  parameter int DU          = 10,
  parameter int DV          = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_slot,
  output logic [7:0]  rd_addr,
  input  logic [11:0] rd_data,
  output logic        ct_valid,
  output logic [7:0]  ct_data,
  output logic        ct_last,
  input  logic        ct_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_EMIT, S_FIN} state_t;

  localparam logic [11:0] DU_MASK   = 12'((1 << DU) - 1);
  localparam logic [11:0] DV_MASK   = 12'((1 << DV) - 1);
  localparam logic [10:0] LAST_BYTE = 11'd1087;

  state_t      state_q, state_d;
  logic [4:0]  slot_q, slot_d;
  logic [7:0]  addr_q, addr_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  lat_q, lat_d;
  logic [17:0] acc_q, acc_d;
  logic [4:0]  fill_q, fill_d;
  logic [10:0] byte_q, byte_d;

  logic        is_u;
  logic [11:0] mask;
  logic [4:0]  dw;
  logic [17:0] merged;
  logic [4:0]  fill_m;
  logic [4:0]  fill_e;
  logic        advance;
  logic        slot_change;

  assign busy     = (state_q == S_RD) || (state_q == S_EMIT);
  assign done     = (state_q == S_FIN);
  assign rd_slot  = (state_q == S_RD) ? slot_q : 5'd0;
  assign rd_addr  = (state_q == S_RD) ? addr_q : 8'd0;
  assign ct_valid = (state_q == S_EMIT);
  assign ct_data  = (state_q == S_EMIT) ? acc_q[7:0] : 8'd0;
  assign ct_last  = (state_q == S_EMIT) && (byte_q == LAST_BYTE);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    byte_d  = byte_q;
    advance = 1'b0;

    is_u   = idx_q < 3'(K);
    mask   = is_u ? DU_MASK : DV_MASK;
    dw     = is_u ? 5'(DU) : 5'(DV);
    merged = acc_q | (18'(rd_data & mask) << fill_q);
    fill_m = fill_q + dw;
    fill_e = fill_q - 5'd8;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD;
          slot_d  = 5'(U_SLOT_BASE);
          addr_d  = 8'd0;
          idx_d   = 3'd0;
          lat_d   = 2'd0;
          acc_d   = 18'd0;
          fill_d  = 5'd0;
          byte_d  = 11'd0;
        end
      end
      S_RD: begin
        if (lat_q == 2'(READ_LAT - 1)) begin
          lat_d  = 2'd0;
          acc_d  = merged;
          fill_d = fill_m;
          if (fill_m >= 5'd8) state_d = S_EMIT;
          else                advance = 1'b1;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_EMIT: begin
        if (ct_ready) begin
          acc_d  = acc_q >> 8;
          fill_d = fill_e;
          byte_d = byte_q + 11'd1;
          if (fill_e < 5'd8) advance = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Coefficient advance is folded into the RD/EMIT exit so it costs no cycle.
    if (advance) begin
      addr_d  = addr_q + 8'd1;
      state_d = S_RD;
      if (addr_q == 8'd255) begin
        if (idx_q == 3'(K)) begin
          state_d = S_FIN;
        end else begin
          idx_d  = idx_q + 3'd1;
          slot_d = ((idx_q + 3'd1) < 3'(K)) ? 5'(U_SLOT_BASE) + 5'(idx_q) + 5'd1
                                            : 5'(V_SLOT);
        end
      end
    end
  end

  assign slot_change = advance && (addr_q == 8'd255);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      slot_q  <= 5'd0;
      addr_q  <= 8'd0;
      idx_q   <= 3'd0;
      lat_q   <= 2'd0;
      acc_q   <= 18'd0;
      fill_q  <= 5'd0;
      byte_q  <= 11'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      byte_q  <= byte_d;
    end
  end

  // Every polynomial ends on a byte boundary; leftover bits here mean a broken encoder.
  always_ff @(posedge clk) begin
    if (rst_n && slot_change) assert (fill_d == 5'd0);
  end

endmodule

// File: tb/tb_ct_byte_packer.sv
// tb/tb_ct_byte_packer.sv - self-checking bench for ct_byte_packer
// Two instances (READ_LAT 1 and 3) share a bank model and a ByteEncode reference.
module tb_ct_byte_packer;

  logic        clk;
  logic        rst_n;
  logic        ct_ready;
  logic        start    [2];
  logic        busy     [2];
  logic        done     [2];
  logic [4:0]  rd_slot  [2];
  logic [7:0]  rd_addr  [2];
  logic [11:0] rd_data  [2];
  logic        ct_valid [2];
  logic [7:0]  ct_data  [2];
  logic        ct_last  [2];

  logic [11:0] mem   [4][256];
  logic [7:0]  exp_b [1088];
  logic [7:0]  got   [1088];
  logic [4:0]  s1a, s1b;
  logic [7:0]  a1a, a1b;

  int vectors;
  int miscompares;

  ct_byte_packer #(.READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .rd_slot(rd_slot[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .ct_valid(ct_valid[0]), .ct_data(ct_data[0]), .ct_last(ct_last[0]), .ct_ready(ct_ready)
  );

  ct_byte_packer #(.READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .rd_slot(rd_slot[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .ct_valid(ct_valid[1]), .ct_data(ct_data[1]), .ct_last(ct_last[1]), .ct_ready(ct_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: zero latency beyond the sampling cycle for LAT 1, two extra stages for LAT 3.
  always_ff @(posedge clk) begin
    s1a <= rd_slot[1];
    a1a <= rd_addr[1];
    s1b <= s1a;
    a1b <= a1a;
  end

  always_comb begin
    rd_data[0] = (rd_slot[0] >= 5'd16 && rd_slot[0] <= 5'd19) ? mem[rd_slot[0][1:0]][rd_addr[0]] : 12'd0;
    rd_data[1] = (s1b >= 5'd16 && s1b <= 5'd19) ? mem[s1b[1:0]][a1b] : 12'd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic fill_mem(input int mode);
    for (int p = 0; p < 4; p++)
      for (int j = 0; j < 256; j++)
        mem[p][j] = (mode == 1) ? 12'd0 : 12'($urandom);
    if (mode == 1) begin
      mem[0][0] = 12'h001; mem[0][1] = 12'h002; mem[0][2] = 12'h003; mem[0][3] = 12'h004;
    end else if (mode == 2) begin
      mem[0][0] = 12'hFFF; mem[0][1] = 12'h000; mem[3][0] = 12'h005; mem[3][1] = 12'h00A;
    end
  endtask

  // Reference: concatenate every coefficient's low d bits LSB-first, then cut into bytes.
  task automatic build_expected();
    bit bits[$];
    int d;
    for (int p = 0; p < 4; p++) begin
      d = (p < 3) ? 10 : 4;
      for (int j = 0; j < 256; j++)
        for (int b = 0; b < d; b++)
          bits.push_back(mem[p][j][b]);
    end
    for (int n = 0; n < 1088; n++)
      for (int k = 0; k < 8; k++)
        exp_b[n][k] = bits[8*n + k];
  endtask

  task automatic check_idle_outputs(input int inst, input string tag);
    chk({tag, "_busy"},     busy[inst],     0);
    chk({tag, "_done"},     done[inst],     0);
    chk({tag, "_ct_valid"}, ct_valid[inst], 0);
    chk({tag, "_ct_data"},  ct_data[inst],  0);
    chk({tag, "_ct_last"},  ct_last[inst],  0);
    chk({tag, "_rd_slot"},  rd_slot[inst],  0);
    chk({tag, "_rd_addr"},  rd_addr[inst],  0);
  endtask

  task automatic run_frame(input int inst, input int mode, input int ready_pct,
                           input bit spam, input int abort_at);
    int nbytes, busy_cnt, last_hs, lat;
    bit finished, pend, pend_last, rdy;
    logic [7:0] pend_data;
    logic [7:0] basic_ref [5];
    basic_ref = '{8'h01, 8'h08, 8'h30, 8'h00, 8'h01};
    lat = (inst == 0) ? 1 : 3;
    nbytes = 0; busy_cnt = 0; last_hs = -10; finished = 0; pend = 0;
    pend_last = 0; pend_data = 8'd0;
    fill_mem(mode);
    build_expected();

    start[inst] = 1'b1;
    @(negedge clk);
    start[inst] = 1'b0;
    chk("start_busy",    busy[inst],    1);
    chk("start_rd_slot", rd_slot[inst], 16);
    chk("start_rd_addr", rd_addr[inst], 0);

    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (busy[inst]) busy_cnt++;
      if (pend) begin
        chk("stall_valid", ct_valid[inst], 1);
        chk("stall_data",  ct_data[inst],  pend_data);
        chk("stall_last",  ct_last[inst],  pend_last);
      end
      if (ct_valid[inst]) chk("no_read_while_pending", {rd_slot[inst], rd_addr[inst]}, 0);
      if (done[inst]) begin
        chk("done_after_last_hs", last_hs, cyc - 1);
        chk("busy_low_at_done",   busy[inst], 0);
        finished = 1;
        if (spam) start[inst] = 1'b1;
        break;
      end
      rdy = ($urandom_range(99) < ready_pct);
      if (abort_at >= 0 && nbytes == abort_at && ct_valid[inst]) begin
        ct_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs(inst, "abort_reset");
        rst_n = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk("abort_no_done", done[inst], 0);
          chk("abort_no_busy", busy[inst], 0);
        end
        return;
      end
      if (spam && busy[inst] && $urandom_range(15) == 0) start[inst] = 1'b1;
      ct_ready = rdy;
      if (ct_valid[inst] && rdy) begin
        chk("byte_in_range", nbytes < 1088, 1);
        if (nbytes < 1088) begin
          got[nbytes] = ct_data[inst];
          chk($sformatf("byte_%0d", nbytes), ct_data[inst], exp_b[nbytes]);
          chk($sformatf("last_%0d", nbytes), ct_last[inst], nbytes == 1087);
        end
        nbytes++;
        last_hs = cyc;
        pend = 0;
      end else begin
        pend      = ct_valid[inst];
        pend_data = ct_data[inst];
        pend_last = ct_last[inst];
      end
      @(negedge clk);
      start[inst] = 1'b0;
    end

    chk("frame_finished", finished, 1);
    chk("byte_count", nbytes, 1088);
    if (ready_pct == 100) chk("busy_cycles", busy_cnt, 1024*lat + 1088);
    ct_ready = 1'b0;
    @(negedge clk);
    start[inst] = 1'b0;
    chk("no_restart_busy", busy[inst], 0);
    chk("done_one_cycle",  done[inst], 0);
    if (mode == 1)
      for (int i = 0; i < 5; i++) chk($sformatf("basic_byte_%0d", i), got[i], basic_ref[i]);
    if (mode == 2) begin
      chk("mask_byte0",   got[0],   8'hFF);
      chk("mask_byte1",   got[1],   8'h03);
      chk("mask_byte960", got[960], 8'hA5);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    ct_ready = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs(0, "reset_lat1");
    check_idle_outputs(1, "reset_lat3");
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(0, 1, 100, 1'b0, -1);
    run_frame(0, 2, 100, 1'b0, -1);
    run_frame(0, 0, 100, 1'b0, -1);
    run_frame(1, 0, 100, 1'b0, -1);
    run_frame(0, 0, 30,  1'b1, -1);
    run_frame(1, 0, 30,  1'b1, -1);
    run_frame(0, 0, 30,  1'b0, 500);
    run_frame(0, 0, 70,  1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
